// File: rtl/fetch_aligner_if.sv
// Bundle between fetch_aligner and its environment: word-aligned memory request/response,
// aligned instruction handshake and execute-side redirect.
interface fetch_aligner_if;
   localparam int unsigned RISCV_WORD_WIDTH = 32;

   logic                        redirect_i;
   logic [RISCV_WORD_WIDTH-1:0] redirect_pc_i;
   logic                        mem_req_o;
   logic [RISCV_WORD_WIDTH-1:0] mem_addr_o;
   logic                        mem_gnt_i;
   logic                        mem_rvalid_i;
   logic [RISCV_WORD_WIDTH-1:0] mem_rdata_i;
   logic                        instr_valid_o;
   logic                        instr_ready_i;
   logic [RISCV_WORD_WIDTH-1:0] instr_o;
   logic [RISCV_WORD_WIDTH-1:0] instr_pc_o;

   // The aligner is the master of the memory request and of the instruction stream.
   modport master (
      input  redirect_i,
      input  redirect_pc_i,
      input  mem_gnt_i,
      input  mem_rvalid_i,
      input  mem_rdata_i,
      input  instr_ready_i,
      output mem_req_o,
      output mem_addr_o,
      output instr_valid_o,
      output instr_o,
      output instr_pc_o
   );

   modport slave (
      output redirect_i,
      output redirect_pc_i,
      output mem_gnt_i,
      output mem_rvalid_i,
      output mem_rdata_i,
      output instr_ready_i,
      input  mem_req_o,
      input  mem_addr_o,
      input  instr_valid_o,
      input  instr_o,
      input  instr_pc_o
   );
endinterface

// File: rtl/fetch_aligner.sv
// Fetch word buffer and 16/32-bit instruction aligner feeding the decompressor.
// Optional FETCH_ALIGNER_PERF_EN adds compressed/straddle accept counters.
module fetch_aligner #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   fetch_aligner_if.master bus
`ifdef FETCH_ALIGNER_PERF_EN
   ,
   output logic [31:0]     compressed_cnt_o,
   output logic [31:0]     straddle_cnt_o
`endif
);

   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
   // Discards accumulate across back-to-back redirects, so give them headroom.
   localparam int unsigned DiscW = 16;

   typedef logic [CntW-1:0] cnt_t;

   logic [31:0]      fifo_q [FIFO_DEPTH];
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  next_ptr;
   cnt_t             count_q, count_d;
   cnt_t             outst_q, outst_d;
   logic [DiscW-1:0] discard_q, discard_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      fetch_addr_q, fetch_addr_d;

   logic [31:0] head_word;
   logic [31:0] next_word;
   logic [15:0] head_half;
   logic        compressed;
   logic        straddle;
   cnt_t        need;
   logic        valid;
   logic        req;
   logic        grant;
   logic        rsp_drop;
   logic        push;
   logic        accept;
   logic        pop;
   logic        unused_redirect_lsb;

   assign unused_redirect_lsb = bus.redirect_pc_i[0];

   assign next_ptr  = rd_ptr_q + PtrW'(1);
   assign head_word = fifo_q[rd_ptr_q];
   assign next_word = fifo_q[next_ptr];

   // The halfword at pc decides the instruction length.
   assign head_half  = pc_q[1] ? head_word[31:16] : head_word[15:0];
   assign compressed = (head_half[1:0] != 2'b11);
   assign straddle   = pc_q[1] & ~compressed;
   assign need       = straddle ? cnt_t'(2) : cnt_t'(1);
   assign valid      = ~rst & (count_q >= need);

   assign req      = ~rst & (cnt_t'(count_q + outst_q) < cnt_t'(FIFO_DEPTH));
   assign grant    = req & bus.mem_gnt_i;
   assign rsp_drop = bus.mem_rvalid_i & (discard_q != '0);
   assign push     = bus.mem_rvalid_i & ~rsp_drop & ~bus.redirect_i;
   assign accept   = valid & bus.instr_ready_i & ~bus.redirect_i;
   // Head word is used up when the next pc leaves it, including a straddle.
   assign pop      = accept & (pc_q[1] | ~compressed);

   always_comb begin
      bus.mem_req_o     = req;
      bus.mem_addr_o    = fetch_addr_q;
      bus.instr_valid_o = valid;
      bus.instr_pc_o    = rst ? RESET_PC : pc_q;
      bus.instr_o       = '0;
      if (valid) begin
         if (compressed) begin
            bus.instr_o = {16'h0000, head_half};
         end else if (straddle) begin
            bus.instr_o = {next_word[15:0], head_word[31:16]};
         end else begin
            bus.instr_o = head_word;
         end
      end
   end

   always_comb begin
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      count_d      = count_q;
      outst_d      = outst_q;
      discard_d    = discard_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      if (bus.redirect_i) begin
         pc_d         = {bus.redirect_pc_i[31:1], 1'b0};
         fetch_addr_d = {bus.redirect_pc_i[31:2], 2'b00};
         count_d      = '0;
         outst_d      = '0;
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         // Everything in flight, including a same-cycle grant, returns as junk.
         discard_d    = discard_q + DiscW'(outst_q) + DiscW'(grant) - DiscW'(bus.mem_rvalid_i);
      end else begin
         if (grant) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
         end
         outst_d = outst_q + cnt_t'(grant) - cnt_t'(push);
         if (rsp_drop) begin
            discard_d = discard_q - DiscW'(1);
         end
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = next_ptr;
         end
         if (accept) begin
            pc_d = pc_q + (compressed ? 32'd2 : 32'd4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         fetch_addr_q <= {RESET_PC[31:2], 2'b00};
         count_q      <= '0;
         outst_q      <= '0;
         discard_q    <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
      end else begin
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         count_q      <= count_d;
         outst_q      <= outst_d;
         discard_q    <= discard_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
      end
   end

   // Word storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= bus.mem_rdata_i;
      end
   end

`ifdef FETCH_ALIGNER_PERF_EN
   logic [31:0] compressed_cnt_q;
   logic [31:0] straddle_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         compressed_cnt_q <= '0;
         straddle_cnt_q   <= '0;
      end else begin
         if (accept && compressed) begin
            compressed_cnt_q <= compressed_cnt_q + 32'd1;
         end
         if (accept && straddle) begin
            straddle_cnt_q <= straddle_cnt_q + 32'd1;
         end
      end
   end

   assign compressed_cnt_o = compressed_cnt_q;
   assign straddle_cnt_o   = straddle_cnt_q;
`endif

   rvalid_has_owner: assert property (@(posedge clk) disable iff (rst)
      !(bus.mem_rvalid_i && outst_q == '0 && discard_q == '0));

endmodule

// File: tb/tb_fetch_aligner.sv
// Random + directed bench for fetch_aligner: in-order memory responder, count-level model of
// request/valid rules, and expected instructions decoded straight from the memory image.
module tb_fetch_aligner;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_aligner_if bus ();

`ifdef FETCH_ALIGNER_PERF_EN
   logic [31:0] cc_cnt;
   logic [31:0] st_cnt;
`endif

   fetch_aligner #(
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FETCH_ALIGNER_PERF_EN
      ,
      .compressed_cnt_o (cc_cnt),
      .straddle_cnt_o   (st_cnt)
`endif
   );

   logic [31:0] img [128];
   logic [31:0] pend_addr [$];
   int          pend_cyc [$];
   logic [31:0] acc_pc [$];
   logic [31:0] acc_ins [$];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int gnt_pct, rsp_pct, rdy_pct, rsp_budget, grant_cnt;
   logic        redir;
   logic [31:0] redir_pc;

   // Model state: pc, fetch address and word counts only.
   logic [31:0] m_pc, m_faddr;
   int m_cnt, m_out, m_disc;
   int m_ccnt, m_scnt;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return img[a[8:2]];
   endfunction

   function automatic logic [15:0] half_at(input logic [31:0] a);
      logic [31:0] w;
      w = word_at(a);
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   function automatic logic [31:0] instr_at(input logic [31:0] pc);
      logic [15:0] h;
      h = half_at(pc);
      if (h[1:0] != 2'b11) return {16'h0000, h};
      return {half_at(pc + 32'd2), h};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: compare at the falling edge, drive inputs, advance model, wait an edge.
   task automatic tick();
      logic [15:0] h;
      logic comp, need2, exp_req, exp_valid, gnt, rv, rdy, grant, hs;
      h         = half_at(m_pc);
      comp      = (h[1:0] != 2'b11);
      need2     = m_pc[1] & ~comp;
      exp_req   = (m_cnt + m_out) < DEPTH;
      exp_valid = m_cnt >= (need2 ? 2 : 1);
      chk("mem_req_o", 32'(bus.mem_req_o), 32'(exp_req));
      chk("mem_addr_o", bus.mem_addr_o, m_faddr);
      chk("instr_valid_o", 32'(bus.instr_valid_o), 32'(exp_valid));
      chk("instr_pc_o", bus.instr_pc_o, m_pc);
      if (exp_valid) chk("instr_o", bus.instr_o, instr_at(m_pc));
`ifdef FETCH_ALIGNER_PERF_EN
      chk("compressed_cnt_o", cc_cnt, 32'(m_ccnt));
      chk("straddle_cnt_o", st_cnt, 32'(m_scnt));
`endif
      gnt = ($urandom_range(99) < gnt_pct);
      rdy = ($urandom_range(99) < rdy_pct);
      rv  = 1'b0;
      if (pend_addr.size() > 0 && pend_cyc[0] < cyc && rsp_budget != 0 &&
          $urandom_range(99) < rsp_pct) rv = 1'b1;
      bus.mem_gnt_i     = gnt;
      bus.mem_rvalid_i  = rv;
      bus.mem_rdata_i   = rv ? word_at(pend_addr[0]) : $urandom;
      bus.instr_ready_i = rdy;
      bus.redirect_i    = redir;
      bus.redirect_pc_i = redir_pc;
      if (bus.mem_req_o && gnt) begin
         pend_addr.push_back(bus.mem_addr_o);
         pend_cyc.push_back(cyc);
         grant_cnt++;
      end
      if (rv) begin
         void'(pend_addr.pop_front());
         void'(pend_cyc.pop_front());
         if (rsp_budget > 0) rsp_budget--;
      end
      if (bus.instr_valid_o && rdy && !redir) begin
         acc_pc.push_back(bus.instr_pc_o);
         acc_ins.push_back(bus.instr_o);
      end
      grant = exp_req & gnt;
      hs    = exp_valid & rdy;
      if (redir) begin
         m_disc  = m_disc + m_out + int'(grant) - int'(rv);
         m_out   = 0;
         m_cnt   = 0;
         m_pc    = {redir_pc[31:1], 1'b0};
         m_faddr = {redir_pc[31:2], 2'b00};
      end else begin
         if (grant) begin
            m_faddr = m_faddr + 32'd4;
            m_out++;
         end
         if (rv) begin
            if (m_disc > 0) m_disc--;
            else begin
               m_cnt++;
               m_out--;
            end
         end
         if (hs) begin
            if (m_pc[1] | ~comp) m_cnt--;
            if (comp) m_ccnt++;
            else if (m_pc[1]) m_scnt++;
            m_pc = m_pc + (comp ? 32'd2 : 32'd4);
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      redir = 1'b0;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redir    = 1'b1;
      redir_pc = pc;
      tick();
   endtask

   task automatic drain();
      gnt_pct = 0; rsp_pct = 100; rsp_budget = -1; rdy_pct = 0;
      for (int i = 0; i < 40 && pend_addr.size() > 0; i++) tick();
      chk("drain_done", 32'(pend_addr.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] e_pc [6];
      logic [31:0] e_in [6];
      int base;
      for (int i = 0; i < 128; i++) img[i] = $urandom;
      img[0]  = 32'h0013_0513;
      img[1]  = 32'h4505_4501;
      img[2]  = 32'h0000_0013;
      img[3]  = 32'h0513_4501;
      img[4]  = 32'h0000_0013;
      img[64] = 32'h1234_4501;
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
      bus.instr_ready_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;
      redir = 1'b0; redir_pc = '0; grant_cnt = 0;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
         chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
         chk("rst_instr", bus.instr_o, 32'd0);
         chk("rst_pc", bus.instr_pc_o, 32'd0);
      end
      rst = 1'b0;
      #1;
      chk("post_rst_req", 32'(bus.mem_req_o), 32'd1);
      chk("post_rst_addr", bus.mem_addr_o, 32'd0);
      m_pc = '0; m_faddr = '0; m_cnt = 0; m_out = 0; m_disc = 0; m_ccnt = 0; m_scnt = 0;

      // Straight-line stream with aligned, compressed and straddling instructions.
      gnt_pct = 100; rsp_pct = 100; rdy_pct = 100; rsp_budget = -1;
      tick();
      chk("second_req_addr", bus.mem_addr_o, 32'h4);
      for (int i = 0; i < 60 && acc_pc.size() < 6; i++) tick();
      e_pc = '{32'h0, 32'h4, 32'h6, 32'h8, 32'hC, 32'hE};
      e_in = '{32'h0013_0513, 32'h0000_4501, 32'h0000_4505, 32'h0000_0013,
               32'h0000_4501, 32'h0013_0513};
      chk("dir_stream_len", 32'(acc_pc.size() >= 6), 32'd1);
      if (acc_pc.size() >= 6) begin
         for (int i = 0; i < 6; i++) begin
            chk("dir_stream_pc", acc_pc[i], e_pc[i]);
            chk("dir_stream_instr", acc_ins[i], e_in[i]);
         end
      end

      // Straddle must wait for its second word.
      drain();
      redirect_to(32'hE);
      rsp_budget = 0; gnt_pct = 100;
      tick(); tick();
      chk("two_outstanding_req", 32'(bus.mem_req_o), 32'd0);
      rsp_budget = 1; rsp_pct = 100;
      tick();
      chk("straddle_wait_valid", 32'(bus.instr_valid_o), 32'd0);
      rsp_budget = 1;
      tick();
      chk("straddle_valid", 32'(bus.instr_valid_o), 32'd1);
      chk("straddle_instr", bus.instr_o, 32'h0013_0513);
      chk("straddle_pc", bus.instr_pc_o, 32'hE);

      // Backpressure: only FIFO_DEPTH grants, nothing lost afterwards.
      drain();
      redirect_to(32'h0);
      base = acc_pc.size();
      grant_cnt = 0; gnt_pct = 100; rsp_pct = 100; rsp_budget = -1; rdy_pct = 0;
      for (int i = 0; i < 10; i++) tick();
      chk("bp_grants", 32'(grant_cnt), 32'd2);
      chk("bp_req_low", 32'(bus.mem_req_o), 32'd0);
      chk("bp_valid", 32'(bus.instr_valid_o), 32'd1);
      rdy_pct = 100;
      for (int i = 0; i < 30 && acc_pc.size() < base + 2; i++) tick();
      chk("bp_acc_len", 32'(acc_pc.size() >= base + 2), 32'd1);
      if (acc_pc.size() >= base + 2) begin
         chk("bp_pc0", acc_pc[base], 32'h0);
         chk("bp_instr0", acc_ins[base], 32'h0013_0513);
         chk("bp_pc1", acc_pc[base+1], 32'h4);
         chk("bp_instr1", acc_ins[base+1], 32'h0000_4501);
      end

      // Redirect with two requests in flight: their data must be dropped.
      drain();
      redirect_to(32'h40);
      rsp_budget = 0; gnt_pct = 100;
      tick(); tick(); tick();
      chk("ro_req_full", 32'(bus.mem_req_o), 32'd0);
      redirect_to(32'h0000_0102);
      chk("ro_addr", bus.mem_addr_o, 32'h100);
      chk("ro_req", 32'(bus.mem_req_o), 32'd1);
      chk("ro_valid", 32'(bus.instr_valid_o), 32'd0);
      base = acc_pc.size();
      rsp_budget = -1; rsp_pct = 100; rdy_pct = 100;
      for (int i = 0; i < 30 && acc_pc.size() <= base; i++) tick();
      chk("ro_acc_len", 32'(acc_pc.size() > base), 32'd1);
      if (acc_pc.size() > base) begin
         chk("ro_first_pc", acc_pc[base], 32'h102);
         chk("ro_first_instr", acc_ins[base], 32'h0000_1234);
      end

      // Redirect coinciding with a handshake and an rvalid.
      drain();
      redirect_to(32'h60);
      rsp_budget = 0; gnt_pct = 100;
      tick(); tick(); tick();
      rsp_budget = 1; rsp_pct = 100;
      tick();
      chk("sc_pre_valid", 32'(bus.instr_valid_o), 32'd1);
      rsp_budget = 1; rdy_pct = 100; gnt_pct = 0;
      redirect_to(32'h20);
      chk("sc_valid_low", 32'(bus.instr_valid_o), 32'd0);
      chk("sc_pc", bus.instr_pc_o, 32'h20);

      // Random traffic with occasional redirects, some near the top of the address space.
      rsp_budget = -1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) begin
            gnt_pct = 20 + $urandom_range(80);
            rsp_pct = 20 + $urandom_range(80);
            rdy_pct = $urandom_range(100);
         end
         if ($urandom_range(99) < 3) begin
            redir    = 1'b1;
            redir_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                : ($urandom & 32'h0000_01FF);
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
